param_mode_counter: RTL and testbench

- Parametrised successor to the team's fixed 4-bit synchronous counter.
- Programmable terminal value, up/down direction, synchronous load, count enable, and three terminal-count modes: wrap, one-shot, saturate.
- Combinational terminal-count output for cascading, plus a registered one-shot completion flag.
- Used as the general timer/sequencer counter in datapath and test designs.

---
 rtl/pmc_pkg.sv | 18 +
 rtl/pmc_reg.sv | 20 ++
 rtl/param_mode_counter.sv | 109 ++++++++++
 tb/tb_param_mode_counter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pmc_pkg.sv
// Purpose : shared types for param_mode_counter (terminal-count modes, run/halt state).
// Latency : n/a (types only).
// Backpressure: n/a.
package pmc_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_ONESHOT = 2'd1,
    MODE_SAT     = 2'd2,
    MODE_RSVD    = 2'd3
  } cnt_mode_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } pmc_state_t;

endpackage

// File: rtl/pmc_reg.sv
// Purpose : plain WIDTH-bit register, asynchronous active-high reset to zero.
// Latency : 1 cycle from d to q.
// Backpressure: none; loads d on every rising clk edge.
//
// Ports: clk (clock), R (async reset, active high), d (next value), q (registered value).
module pmc_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             R,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge R) begin
    if (R) q <= '0;
    else   q <= d;
  end

endmodule

// File: rtl/param_mode_counter.sv
// Purpose : up/down counter with programmable terminal value and wrap/one-shot/saturate modes.
// Latency : 1 cycle from en/load to count change; tc is combinational from count and inputs.
// Backpressure: none; en is the only flow control (and tc is meant to feed a cascaded en).
//
// Ports: clk, R (async active-high reset), en, load, load_val, max_count, dir (0 up / 1 down),
//        mode (cnt_mode_t encoding, 3 behaves as wrap), count (registered), tc (combinational),
//        done (registered, one-shot expired), presc_div (only with PMC_PRESCALE_EN).
// Build option: define PMC_PRESCALE_EN to add a prescaler so the counter advances once per
//        presc_div+1 enabled cycles.
module param_mode_counter
  import pmc_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  R,
  input  logic                  en,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      max_count,
  input  logic                  dir,
  input  logic [1:0]            mode,
`ifdef PMC_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] presc_div,
`endif
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  done
);

  generate
    if (WIDTH < 2 || WIDTH > 32 || PRESCALE_W < 1) begin : g_bad_param
      $error("param_mode_counter: WIDTH must be 2..32 and PRESCALE_W >= 1");
    end
  endgenerate

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  pmc_state_t       state, state_nxt;
  cnt_mode_t        mode_e;
  logic [WIDTH-1:0] count_nxt;
  logic             eff_en;
  logic             term;
  logic             run;

  assign mode_e = cnt_mode_t'(mode);

`ifdef PMC_PRESCALE_EN
  logic [PRESCALE_W-1:0] pcnt, pcnt_nxt;

  // Prescaler keeps running in HALT; it only gates when the main counter may step.
  always_comb begin
    pcnt_nxt = pcnt;
    if (load)                   pcnt_nxt = '0;
    else if (en && pcnt == presc_div) pcnt_nxt = '0;
    else if (en)                pcnt_nxt = pcnt + PRESCALE_W'(1);
  end

  pmc_reg #(.WIDTH(PRESCALE_W)) u_pcnt (
    .clk (clk),
    .R   (R),
    .d   (pcnt_nxt),
    .q   (pcnt)
  );

  assign eff_en = en & (pcnt == presc_div);
`else
  assign eff_en = en;
`endif

  // >= rather than == so lowering max_count below the current count still terminates.
  assign term = dir ? (count == '0) : (count >= max_count);
  assign run  = (state == ST_RUN);
  assign tc   = eff_en & run & term;
  assign done = (state == ST_HALT);

  always_comb begin
    count_nxt = count;
    state_nxt = state;
    if (load) begin
      count_nxt = (load_val > max_count) ? max_count : load_val;
      state_nxt = ST_RUN;
    end else if (eff_en && run) begin
      if (!term) begin
        count_nxt = dir ? (count - ONE) : (count + ONE);
      end else begin
        case (mode_e)
          MODE_ONESHOT: state_nxt = ST_HALT;
          MODE_SAT:     count_nxt = count;
          default:      count_nxt = dir ? max_count : '0;  // WRAP and reserved
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) state <= ST_RUN;
    else   state <= state_nxt;
  end

  pmc_reg #(.WIDTH(WIDTH)) u_count (
    .clk (clk),
    .R   (R),
    .d   (count_nxt),
    .q   (count)
  );

endmodule

// File: tb/tb_param_mode_counter.sv
// Purpose : self-checking bench for param_mode_counter (WIDTH=4) against an integer model.
// Latency : n/a.
// Backpressure: n/a.
module tb_param_mode_counter;

  localparam int W  = 4;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          R;
  logic          en;
  logic          load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  max_count;
  logic          dir;
  logic [1:0]    mode;
  logic [PW-1:0] presc_div;
  logic [W-1:0]  count;
  logic          tc;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_count = 0;
  int m_halt  = 0;
  int m_p     = 0;

  always #5 clk = ~clk;

  param_mode_counter #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk       (clk),
    .R         (R),
    .en        (en),
    .load      (load),
    .load_val  (load_val),
    .max_count (max_count),
    .dir       (dir),
    .mode      (mode),
`ifdef PMC_PRESCALE_EN
    .presc_div (presc_div),
`endif
    .count     (count),
    .tc        (tc),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_eff_en();
`ifdef PMC_PRESCALE_EN
    return (en && (m_p == int'(presc_div))) ? 1 : 0;
`else
    return en ? 1 : 0;
`endif
  endfunction

  function automatic int model_term();
    if (dir) return (m_count == 0) ? 1 : 0;
    return (m_count >= int'(max_count)) ? 1 : 0;
  endfunction

  // Checks outputs for the current cycle, then advances DUT and model by one edge.
  task automatic tick();
    int e, t, nc, nh, np;
    #1;
    e = model_eff_en();
    t = model_term();
    check("count", count, m_count);
    check("done", done, m_halt);
    check("tc", tc, (e && !m_halt && t) ? 1 : 0);
    nc = m_count; nh = m_halt; np = m_p;
    if (load) begin
      nc = (int'(load_val) < int'(max_count)) ? int'(load_val) : int'(max_count);
      nh = 0;
    end else if (e && !m_halt) begin
      if (!t) nc = dir ? m_count - 1 : m_count + 1;
      else if (mode == 2'd1) nh = 1;
      else if (mode == 2'd2) nc = m_count;
      else nc = dir ? int'(max_count) : 0;
    end
    if (load) np = 0;
    else if (en) np = (m_p == int'(presc_div)) ? 0 : (m_p + 1) % (1 << PW);
    @(posedge clk);
    m_count = nc; m_halt = nh; m_p = np;
    #1;
  endtask

  task automatic model_reset();
    m_count = 0; m_halt = 0; m_p = 0;
  endtask

  initial begin
    int seq1 [10];
    int seq2 [6];
    int seq6 [7];
    seq1 = '{0, 1, 2, 3, 4, 5, 6, 0, 1, 2};
    seq2 = '{3, 2, 1, 0, 9, 8};
    seq6 = '{0, 0, 0, 1, 1, 1, 2};

    R = 1'b1; en = 1'b0; load = 1'b0; load_val = '0; max_count = '0;
    dir = 1'b0; mode = 2'd0; presc_div = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_done", done, 0);
    R = 1'b0;
    model_reset();

    // 1: up wrap
    max_count = 4'd6; mode = 2'd0; dir = 1'b0; en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("t1_seq", count, seq1[i]);
      tick();
    end

    // 2: down wrap
    en = 1'b0; load = 1'b1; load_val = 4'd3; dir = 1'b1; max_count = 4'd9;
    tick();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("t2_seq", count, seq2[i]);
      tick();
    end

    // 3: one-shot then reload
    dir = 1'b0; mode = 2'd1; max_count = 4'd4; load = 1'b1; load_val = 4'd0; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
    repeat (6) tick();
    check("t3_count", count, 4);
    check("t3_done", done, 1);
    for (int i = 0; i < 4; i++) begin
      en = i[0];
      tick();
    end
    check("t3_frozen", count, 4);
    load = 1'b1; load_val = 4'd1; en = 1'b0;
    tick();
    check("t3_reload_done", done, 0);
    check("t3_reload_count", count, 1);
    load = 1'b0; en = 1'b1;
    repeat (2) tick();
    check("t3_resume", count, 3);

    // 4: saturate with clamped load and runtime max lowering
    mode = 2'd2; max_count = 4'd5; load = 1'b1; load_val = 4'd12; en = 1'b0;
    tick();
    check("t4_clamp", count, 5);
    load = 1'b0; en = 1'b1;
    repeat (3) tick();
    check("t4_sat_tc", tc, 1);
    max_count = 4'd3;
    #1;
    check("t4_lowered_tc", tc, 1);
    check("t4_lowered_count", count, 5);
    repeat (2) tick();

    // 5: async reset mid-count, with load/en asserted alongside
    mode = 2'd1; max_count = 4'd7; load = 1'b1; load_val = 4'd5; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
    repeat (3) tick();
    check("t5_pre_count", count, 7);
    check("t5_pre_done", done, 1);
    #2;
    R = 1'b1; load = 1'b1; load_val = 4'd2; en = 1'b1;
    #1;
    check("t5_async_count", count, 0);
    check("t5_async_done", done, 0);
    @(posedge clk);
    #1;
    check("t5_hold_count", count, 0);
    check("t5_hold_tc", tc, 0);
    R = 1'b0; load = 1'b0; en = 1'b0;
    model_reset();
    tick();

`ifdef PMC_PRESCALE_EN
    // 6: prescaler
    mode = 2'd0; dir = 1'b0; max_count = 4'd15; presc_div = 4'd2;
    load = 1'b1; load_val = 4'd0; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check("t6_seq", count, seq6[i]);
      tick();
    end
    presc_div = 4'd0; load = 1'b1; load_val = 4'd0;
    tick();
    load = 1'b0;
    repeat (3) tick();
    check("t6_div0", count, 3);
`endif

    // Randomized phase
    for (int i = 0; i < 600; i++) begin
      en   = ($urandom_range(3) != 0);
      load = ($urandom_range(9) == 0);
      load_val = W'($urandom);
      dir  = $urandom_range(1);
      mode = 2'($urandom);
      if ($urandom_range(15) == 0) max_count = W'($urandom);
`ifdef PMC_PRESCALE_EN
      if ($urandom_range(31) == 0) presc_div = PW'($urandom_range(3));
`endif
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
